// File: rtl/aes128_enc_iter_ctrl.sv
// aes128_enc_iter_ctrl: iterative AES-128 encryptor, one full round per clock.
// Build option AES_ABORT_EN adds iAbort to cancel an in-flight block.
module aes128_enc_iter_ctrl (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [127:0] iData,
    input  logic [127:0] iKey,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oData,
`ifdef AES_ABORT_EN
    input  logic         iAbort,
`endif
    output logic         oBusy,
    output logic [3:0]   oRound
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    // Byte x lives at bits [(255-x)*8 +: 8]; row 0 of the table is the MSB.
    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_T[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = sbox(s[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [31:0] o;
        {a3, a2, a1, a0} = a;
        o[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[32*c +: 32] = mix_col(s[32*c +: 32]);
        return o;
    endfunction

    // Row 0 is the low byte of each column word.
    function automatic logic [127:0] key_step(input logic [127:0] k,
                                              input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w3, w2, w1, w0} = k;
        t = {sbox(w3[7:0]), sbox(w3[31:24]),
             sbox(w3[23:16]), sbox(w3[15:8]) ^ rc};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    fsm_t         fsm_q, fsm_nxt;
    logic [127:0] state_reg, state_nxt;
    logic [127:0] key_reg, key_nxt;
    logic [7:0]   rcon_reg, rcon_nxt;
    logic [3:0]   round_reg, round_nxt;

    logic [127:0] sr_out, mc_out, rk_next, round_out;
    logic         last_round;

    assign last_round = (round_reg == 4'd10);
    assign sr_out     = shift_rows(sub_bytes(state_reg));
    assign mc_out     = last_round ? sr_out : mix_columns(sr_out);
    assign rk_next    = key_step(key_reg, rcon_reg);
    assign round_out  = mc_out ^ rk_next;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            fsm_q     <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rcon_reg  <= 8'h01;
            round_reg <= '0;
        end else begin
            fsm_q     <= fsm_nxt;
            state_reg <= state_nxt;
            key_reg   <= key_nxt;
            rcon_reg  <= rcon_nxt;
            round_reg <= round_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm_q;
        state_nxt = state_reg;
        key_nxt   = key_reg;
        rcon_nxt  = rcon_reg;
        round_nxt = round_reg;
        unique case (fsm_q)
            IDLE: begin
                if (iValid) begin
                    state_nxt = iData ^ iKey;
                    key_nxt   = iKey;
                    rcon_nxt  = 8'h01;
                    round_nxt = 4'd1;
                    fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                state_nxt = round_out;
                key_nxt   = rk_next;
                rcon_nxt  = xtime(rcon_reg);
                if (last_round) begin
                    round_nxt = 4'd0;
                    fsm_nxt   = DONE;
                end else begin
                    round_nxt = round_reg + 4'd1;
                end
            end
            DONE: begin
                if (iReady)
                    fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
`ifdef AES_ABORT_EN
        // Abort wins over the DONE handshake; IDLE requests are unaffected.
        if (iAbort && fsm_q != IDLE) begin
            fsm_nxt   = IDLE;
            round_nxt = 4'd0;
        end
`endif
    end

    assign oReady = (fsm_q == IDLE);
    assign oBusy  = (fsm_q == ROUND);
    assign oValid = (fsm_q == DONE);
    assign oData  = state_reg;
    assign oRound = round_reg;

endmodule

// File: tb/tb_aes128_enc_iter_ctrl.sv
// tb_aes128_enc_iter_ctrl: random and FIPS-197 traffic against an array-based
// AES-128 reference model built from GF(2^8) arithmetic.
module tb_aes128_enc_iter_ctrl;

    logic         iClk = 1'b0;
    logic         iRst_n;
    logic         iValid;
    logic         oReady;
    logic [127:0] iData;
    logic [127:0] iKey;
    logic         oValid;
    logic         iReady;
    logic [127:0] oData;
    logic         iAbort;
    logic         oBusy;
    logic [3:0]   oRound;

    int nvec = 0;
    int nerr = 0;
    logic [127:0] r1_obs, ct_obs;
    logic [7:0]   sbt [256];

    always #5 iClk = ~iClk;

    aes128_enc_iter_ctrl dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iData  (iData),
        .iKey   (iKey),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
`ifdef AES_ABORT_EN
        .iAbort (iAbort),
`endif
        .oBusy  (oBusy),
        .oRound (oRound)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse, then affine map.
    task automatic build_sbox();
        logic [7:0] inv, r, acc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            acc = inv;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                acc ^= r;
            end
            sbt[x] = acc ^ 8'h63;
        end
    endtask

    // State after nr rounds (nr=10 gives the ciphertext).
    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [127:0] key,
                                             input int nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            s[k%4][k/4] = pt[8*k +: 8];
            w[k/4][k%4] = key[8*k +: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sbt[w[i-1][(j+1)%4]];
                tmp[0] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] ^= w[c][r];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^
                                  gmul(8'h03, t[(r+1)%4][c]) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] ^= w[4*rd+c][r];
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k%4][k/4];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge with the DUT idle; returns idle again.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key);
        iData  = pt;
        iKey   = key;
        iValid = 1'b1;
        iReady = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        check("accept_busy", 128'(oBusy), 128'(1));
        check("initial_ark", oData, pt ^ key);
        for (int r = 1; r <= 10; r++) begin
            check("round_idx", 128'(oRound), 128'(r));
            check("ready_low", 128'(oReady), 128'(0));
            @(negedge iClk);
            if (r == 1) r1_obs = oData;
            check(r < 10 ? "valid_early" : "valid_t10",
                  128'(oValid), 128'(r == 10));
            check("round_state", oData, aes_ref(pt, key, r));
        end
        ct_obs = oData;
        check("done_round0", 128'(oRound), 128'(0));
        @(negedge iClk);
        check("back_idle", 128'(oReady), 128'(1));
    endtask

    task automatic wait_round(input logic [3:0] rd);
        int n = 0;
        while (oRound != rd && n < 30) begin
            @(negedge iClk);
            n++;
        end
        check("wait_round", 128'(n < 30), 128'(1));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!oValid && n < 30) begin
            @(negedge iClk);
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 128'(oReady), 128'(1));
        check({tag, "_valid"}, 128'(oValid), 128'(0));
        check({tag, "_busy"},  128'(oBusy),  128'(0));
        check({tag, "_round"}, 128'(oRound), 128'(0));
    endtask

    initial begin
        logic [127:0] pa, ka, pb, kb, ea, eb;
        logic [127:0] bp [4];
        logic [127:0] bk [4];
        int n, seen, cyc, last, acc, outc;
        logic prev_ready;

        iRst_n = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iAbort = 1'b0;
        iData  = '0;
        iKey   = '0;
        build_sbox();

        repeat (2) @(negedge iClk);
        check_reset_vals("rst");
        check("rst_data", oData, 128'h0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // FIPS-197 C.1
        run_block(128'hffeeddccbbaa99887766554433221100,
                  128'h0f0e0d0c0b0a09080706050403020100);
        check("c1_ct", ct_obs, 128'h5ac5b47080b7cdd830047b6ad8e0c469);

        // FIPS-197 Appendix B
        run_block(128'h340737e0a29831318d305a88a8f64332,
                  128'h3c4fcf098815f7aba6d2ae2816157e2b);
        check("b_round1", r1_obs, 128'h49506a0243ea5b6b2b359f68f27f9ca4);
        check("b_ct", ct_obs, 128'h320b6a19978511dcfb09dc021d842539);

        // Output backpressure with a second request pending
        pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
        ea = aes_ref(pa, ka, 10);
        eb = aes_ref(pb, kb, 10);
        iData = pa; iKey = ka; iValid = 1'b1; iReady = 1'b0;
        @(negedge iClk);
        iData = pb; iKey = kb;
        wait_valid(n);
        check("bp_latency", 128'(n), 128'(10));
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 128'(oValid), 128'(1));
            check("bp_data", oData, ea);
            check("bp_ready", 128'(oReady), 128'(0));
            @(negedge iClk);
        end
        iReady = 1'b1;
        @(negedge iClk);
        check("bp_idle", 128'(oReady), 128'(1));
        check("bp_nopulse", 128'(oValid), 128'(0));
        @(negedge iClk);
        check("bp_second_acc", 128'(oRound), 128'(1));
        iValid = 1'b0;
        wait_valid(n);
        check("bp_second_ct", oData, eb);
        @(negedge iClk);

        // Reset during round 5
        pa = rnd128(); ka = rnd128();
        iData = pa; iKey = ka; iValid = 1'b1; iReady = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        wait_round(4'd5);
        iRst_n = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b1;
        check_reset_vals("midrst");
        check("midrst_data", oData, 128'h0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge iClk);
            if (oValid) seen++;
        end
        check("midrst_no_valid", 128'(seen), 128'(0));
        run_block(pa, ka);
        check("midrst_ct", ct_obs, aes_ref(pa, ka, 10));

        // Back-to-back random blocks
        for (int i = 0; i < 4; i++) begin
            bp[i] = rnd128();
            bk[i] = rnd128();
        end
        iData = bp[0]; iKey = bk[0]; iValid = 1'b1; iReady = 1'b1;
        prev_ready = oReady;
        cyc = 0; last = -1; acc = 0; outc = 0;
        while (outc < 4 && cyc < 80) begin
            @(negedge iClk);
            cyc++;
            if (prev_ready && oBusy) begin
                if (last >= 0) check("b2b_gap", 128'(cyc - last), 128'(12));
                last = cyc;
                acc++;
                if (acc < 4) begin
                    iData = bp[acc];
                    iKey  = bk[acc];
                end else begin
                    iValid = 1'b0;
                end
            end
            if (oValid) begin
                check("b2b_ct", oData, aes_ref(bp[outc], bk[outc], 10));
                outc++;
            end
            prev_ready = oReady;
        end
        check("b2b_count", 128'(outc), 128'(4));
        @(negedge iClk);

`ifdef AES_ABORT_EN
        // Abort in round 3
        pa = rnd128(); ka = rnd128();
        iData = pa; iKey = ka; iValid = 1'b1; iReady = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        wait_round(4'd3);
        iAbort = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        check_reset_vals("abort_r3");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge iClk);
            if (oValid) seen++;
        end
        check("abort_no_valid", 128'(seen), 128'(0));

        // Abort together with iReady in DONE
        iValid = 1'b1; iReady = 1'b0;
        @(negedge iClk);
        iValid = 1'b0;
        wait_valid(n);
        check("abort_done_lat", 128'(n), 128'(10));
        iAbort = 1'b1; iReady = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        check_reset_vals("abort_done");

        // Abort in IDLE does not block a request
        iAbort = 1'b1; iValid = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0; iValid = 1'b0;
        check("abort_idle_acc", 128'(oRound), 128'(1));
        wait_valid(n);
        check("abort_idle_ct", oData, aes_ref(pa, ka, 10));
        @(negedge iClk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/aes128_enc_iter_ctrl.md
# aes128_enc_iter_ctrl

Iterative AES-128 encryption controller. It sequences one full AES round per clock over a single shared round datapath built from the existing SubBytes, ShiftRows, MixColumns and AddRoundKey combinational blocks. It expands the key on the fly and hands the ciphertext out over a valid/ready interface. It sits between the host-side block buffer and the output FIFO of the DE10 AES core.

## Interface
- No parameters. AES-128 only: 10 rounds, 128-bit key.
- iClk  in  1  system clock; all state updates on the rising edge.
- iRst_n  in  1  reset; synchronous, active-low.
- iValid  in  1  plaintext/key request.
- oReady  out  1  controller idle and able to accept; high only in IDLE.
- iData  in  128  plaintext; column-major packing, byte k at [8k+7:8k], byte k = s[k%4][k/4].
- iKey  in  128  cipher key, same packing as iData.
- oValid  out  1  ciphertext available.
- iReady  in  1  downstream accepts ciphertext.
- oData  out  128  ciphertext, same packing as iData.
- oBusy  out  1  high in ROUND state.
- oRound  out  4  current round index, 0 in IDLE/DONE, 1..10 in ROUND.

## Operation
- Three states: IDLE, ROUND, DONE. Reset puts the block in IDLE.
- IDLE:
  - oReady=1.
  - On iValid=1: load state_reg=iData^iKey, key_reg=iKey, rcon_reg=8'h01, round_reg=1. Go to ROUND.
- ROUND, each cycle:
  - Next round key: w' derived from key_reg.
    - temp = SubWord(RotWord(last column)) ^ {rcon_reg,24'h0} on the column's row-0 byte.
    - Columns are chained by XOR per FIPS-197.
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), w').
  - In round 10, MixColumns is bypassed.
  - key_reg <= w'.
  - rcon_reg <= xtime(rcon_reg), giving 01,02,04,08,10,20,40,80,1b,36.
  - round_reg <= round_reg+1.
  - When round_reg==10, go to DONE. round_reg is not incremented past 10; it clears to 0.
- DONE:
  - oValid=1 and oData=state_reg, held stable until iReady=1.
  - On oValid&&iReady, go to IDLE.
  - A new request is never accepted in the DONE→IDLE cycle.
- iValid while not IDLE is ignored; the host must hold iValid, iData and iKey until oReady.
- oData is driven from state_reg in all states; it is meaningful only when oValid=1.

## Timing
- Reset values, after any rising edge with iRst_n=0:
  - state=IDLE, oReady=1, oValid=0, oBusy=0, oRound=0.
  - state_reg=0, key_reg=0, rcon_reg=8'h01, so oData=0.
- Reset mid-ROUND or in DONE: aborts at that edge; the ciphertext is lost and no oValid pulse follows.
- Latency:
  - Accept edge is T0 (iValid&&oReady sampled high).
  - Rounds 1..10 are computed at edges T1..T10.
  - oValid=1 from T10 onward.
  - Latency is 10 cycles accept→oValid.
- Throughput: minimum 12 cycles per block (1 accept + 10 rounds + 1 DONE handshake).
- oReady, oBusy and oValid decode directly from the state register; none depends combinationally on iValid or iReady.
- All arithmetic is GF(2^8) XOR / xtime; there are no carries and no width growth.

## Configuration
- AES_ABORT_EN:
  - Defined: adds input iAbort (1 bit).
  - iAbort=1 in ROUND or DONE returns the block to IDLE at the next edge, with oValid=0 and oRound=0.
  - iAbort has priority over the DONE handshake.
  - iAbort in IDLE has no effect; a simultaneous iValid is still accepted.
  - Not defined: no port, no abort path.

## Test plan
- FIPS-197 C.1 vector -> oValid exactly 10 cycles after accept.
  - Key: iKey=128'h0f0e0d0c0b0a09080706050403020100.
  - Plaintext: iData=128'hffeeddccbbaa99887766554433221100.
  - Expected: oData=128'h5ac5b47080b7cdd830047b6ad8e0c469.
  - oRound steps 1..10.
- FIPS-197 B vector -> ciphertext 3925841d02dc09fbdc118597196a0b32 (byte-reversed per packing).
  - Key: 2b7e151628aed2a6abf7158809cf4f3c (byte-reversed per packing).
  - Plaintext: 3243f6a8885a308d313198a2e0370734 (byte-reversed per packing).
  - Intermediate round-1 state_reg must match the FIPS-197 Appendix B table.
- Output backpressure:
  - Hold iReady=0 for 20 cycles after oValid -> oData and oValid stable, oReady=0.
  - A second iValid is ignored.
  - Release iReady -> IDLE next cycle, then the second block is accepted.
- Reset mid-operation:
  - Drive iRst_n=0 for one edge at round 5 -> all outputs equal reset values, oValid never pulses.
  - The next request completes with the correct ciphertext.
- Back-to-back traffic:
  - Send 4 random blocks with iValid held high and iReady=1 -> each oData matches the reference model.
  - Accepts are spaced exactly 12 cycles apart.
- AES_ABORT_EN build:
  - iAbort=1 at round 3 -> IDLE next edge, no oValid.
  - iAbort and iReady high together in DONE -> IDLE, with abort taking priority.
